// File: rtl/rs_pkg.sv
// Shared GF(2^8) definitions for the Reed-Solomon datapath blocks.
// Field polynomial x^8+x^4+x^3+x^2+1; elements are plain 8-bit vectors.
// No logic; constants and types only.
package rs_pkg;
  localparam int         GF_W    = 8;
  localparam logic [8:0] GF_POLY = 9'h11D;
  typedef logic [GF_W-1:0] gf_elem_t;
endpackage

// File: rtl/gf2_8_mul.sv
// Combinational GF(2^8) multiplier, shift-and-add with per-step reduction.
// Latency: zero cycles, purely combinational.
// Backpressure: none; caller registers inputs and outputs.
module gf2_8_mul
  import rs_pkg::*;
(
  input  gf_elem_t a_i,
  input  gf_elem_t b_i,
  output gf_elem_t p_o
);

  gf_elem_t acc;
  gf_elem_t sh;

  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < GF_W; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      // sh tracks a*x^(i+1), reduced back into the field every step
      sh = {sh[GF_W-2:0], 1'b0} ^ (sh[GF_W-1] ? GF_POLY[GF_W-1:0] : '0);
    end
    p_o = acc;
  end

endmodule

// File: rtl/gf2_8_mul_arbiter.sv
// Round-robin shares one GF(2^8) multiplier among NUM_REQ requesters, tagged responses.
// Latency: accept at edge k, result valid after edge k+1; 1 op/cycle when unstalled.
// Backpressure: rsp_ready low holds the result; req_ready drops once both stages are full.
module gf2_8_mul_arbiter
  import rs_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic [7:0]           rsp_p,
  output logic                 idle
);

  typedef struct packed {
    logic            found;
    logic [ID_W-1:0] idx;
  } pick_t;

  // Walking offsets high-to-low lets the offset closest to ptr overwrite the rest.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] vld,
                                    input logic [ID_W-1:0]    ptr);
    pick_t r;
    int    j;
    r = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (vld[j]) begin
        r.found = 1'b1;
        r.idx   = ID_W'(j);
      end
    end
    return r;
  endfunction

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_vld_q, s1_vld_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  gf_elem_t        s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic            rsp_vld_q, rsp_vld_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  gf_elem_t        rsp_p_q, rsp_p_d;

  pick_t           pick;
  logic [NUM_REQ-1:0] grant;
  gf_elem_t        a_sel, b_sel, mul_p;
  logic            s1_en, s2_en, xfer;

  gf2_8_mul u_mul (
    .a_i (s1_a_q),
    .b_i (s1_b_q),
    .p_o (mul_p)
  );

  always_comb begin
    pick  = rr_pick(req_valid, ptr_q);
    s2_en = !rsp_vld_q || rsp_ready;
    s1_en = !s1_vld_q || s2_en;
    grant = '0;
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick.found && pick.idx == ID_W'(i)) begin
        grant[i] = 1'b1;
        a_sel    = req_a[8*i +: 8];
        b_sel    = req_b[8*i +: 8];
      end
    end
    xfer      = pick.found && s1_en && !rst;
    req_ready = rst ? '0 : (grant & {NUM_REQ{s1_en}});

    ptr_d = ptr_q;
    if (xfer) ptr_d = (int'(pick.idx) == NUM_REQ - 1) ? '0 : pick.idx + 1'b1;

    s1_vld_d = s1_vld_q;
    s1_id_d  = s1_id_q;
    s1_a_d   = s1_a_q;
    s1_b_d   = s1_b_q;
    if (s1_en) begin
      s1_vld_d = pick.found;
      s1_id_d  = pick.idx;
      s1_a_d   = a_sel;
      s1_b_d   = b_sel;
    end

    rsp_vld_d = rsp_vld_q;
    rsp_id_d  = rsp_id_q;
    rsp_p_d   = rsp_p_q;
    if (s2_en) begin
      rsp_vld_d = s1_vld_q;
      rsp_id_d  = s1_id_q;
      rsp_p_d   = mul_p;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      s1_vld_q  <= 1'b0;
      s1_id_q   <= '0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_p_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      s1_vld_q  <= s1_vld_d;
      s1_id_q   <= s1_id_d;
      s1_a_q    <= s1_a_d;
      s1_b_q    <= s1_b_d;
      rsp_vld_q <= rsp_vld_d;
      rsp_id_q  <= rsp_id_d;
      rsp_p_q   <= rsp_p_d;
    end
  end

  assign rsp_valid = rsp_vld_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_p     = rsp_p_q;
  assign idle      = !s1_vld_q && !rsp_vld_q;

endmodule

// File: tb/tb_gf2_8_mul_arbiter.sv
// Scoreboard bench: transfers push expected (id, product) into a queue, a monitor pops on response.
module tb_gf2_8_mul_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid, req_ready;
  logic [8*N-1:0] req_a, req_b;
  logic           rsp_valid, rsp_ready;
  logic [1:0]     rsp_id;
  logic [7:0]     rsp_p;
  logic           idle;

  always #5 clk = ~clk;

  gf2_8_mul_arbiter #(.NUM_REQ(N), .ID_W(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_p(rsp_p), .idle(idle)
  );

  int tests = 0, fails = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         id;
    logic [7:0] p;
    int         c;
  } exp_t;
  exp_t sbq[$];

  int         model_ptr = 0, inflight = 0, xfer_count = 0;
  logic [N-1:0] taken = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: carry-less product, then long division by 0x11D.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int prod = 0;
    for (int i = 0; i < 8; i++) if (b[i]) prod = prod ^ (int'(a) << i);
    for (int bit_i = 14; bit_i >= 8; bit_i--)
      if (prod[bit_i]) prod = prod ^ (32'h11D << (bit_i - 8));
    return 8'(prod);
  endfunction

  // Request-side observer: arbitration/stall expectations and scoreboard push.
  always @(negedge clk) begin : obs
    int win;
    logic [N-1:0] exp_rdy;
    if (rst) begin
      model_ptr = 0;
      inflight  = 0;
      sbq.delete();
      taken = '0;
    end else begin
      exp_rdy = '0;
      win     = -1;
      if (req_valid != '0 && (inflight < 2 || rsp_ready)) begin
        for (int k = 0; k < N; k++)
          if (win < 0 && req_valid[(model_ptr + k) % N]) win = (model_ptr + k) % N;
        exp_rdy[win] = 1'b1;
      end
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("idle", 32'(idle), 32'(inflight == 0));
      taken = req_valid & req_ready;
      for (int i = 0; i < N; i++) begin
        if (taken[i]) begin
          sbq.push_back('{id: i, p: ref_mul(req_a[8*i +: 8], req_b[8*i +: 8]), c: cyc});
          model_ptr = (i + 1) % N;
          inflight++;
          xfer_count++;
        end
      end
      if (rsp_valid && rsp_ready) inflight--;
    end
  end

  logic       hold_v = 1'b0;
  logic [1:0] hold_id;
  logic [7:0] hold_p;

  always @(negedge clk) begin : mon
    exp_t e;
    if (rst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        check("rsp_hold_valid", 32'(rsp_valid), 32'd1);
        check("rsp_hold_data", 32'({rsp_id, rsp_p}), 32'({hold_id, hold_p}));
      end
      if (rsp_valid && rsp_ready) begin
        if (sbq.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rsp_unexpected: got id %0d p 0x%0h, expected no response", rsp_id, rsp_p);
        end else begin
          e = sbq.pop_front();
          check("rsp_id", 32'(rsp_id), 32'(e.id));
          check("rsp_p", 32'(rsp_p), 32'(e.p));
          check("rsp_latency_min", 32'((cyc - e.c) >= 2), 32'd1);
        end
      end
      hold_v  = rsp_valid && !rsp_ready;
      hold_id = rsp_id;
      hold_p  = rsp_p;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    int g = -1;
    for (int k = 0; k < N; k++) if (v[k]) g = k;
    return g;
  endfunction

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  logic [15:0] op_tbl [3];

  initial begin : main
    int base, guard, g, g_prev, id_prev, opi, waitc, rdy_pct;
    bit first;
    op_tbl[0] = 16'h8080;
    op_tbl[1] = 16'h015A;
    op_tbl[2] = 16'h00FF;

    // 1: reset with every requester asking
    rst = 1'b1; req_valid = '1; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    at_neg();
    check("t1_req_ready", 32'(req_ready), 32'd0);
    check("t1_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t1_idle", 32'(idle), 32'd1);
    tick();
    rst = 1'b0; req_valid = '0;

    // 2: single op, exact latency
    tick();
    req_valid = 4'b0001; req_a[7:0] = 8'h02; req_b[7:0] = 8'h80;
    at_neg();
    check("t2_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    at_neg();
    check("t2_rsp_not_early", 32'(rsp_valid), 32'd0);
    at_neg();
    check("t2_rsp_valid", 32'(rsp_valid), 32'd1);
    check("t2_rsp_p", 32'(rsp_p), 32'h1D);
    check("t2_rsp_id", 32'(rsp_id), 32'd0);

    // 3: all valid, continuous, fixed operand table
    opi = 0; g_prev = 0; id_prev = 0; first = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (first || taken[i]) begin
          {req_a[8*i +: 8], req_b[8*i +: 8]} = op_tbl[opi % 3];
          opi++;
        end
      end
      first = 0;
      req_valid = '1;
      at_neg();
      g = onehot_idx(req_ready);
      if (k > 0) check("t3_grant_rr", 32'(g), 32'((g_prev + 1) % N));
      g_prev = g;
      if (k >= 2) begin
        check("t3_rsp_valid", 32'(rsp_valid), 32'd1);
        if (k >= 3) check("t3_rsp_id_order", 32'(rsp_id), 32'((id_prev + 1) % N));
        id_prev = int'(rsp_id);
      end
    end
    tick();
    req_valid = '0;
    repeat (3) tick();

    // 4: backpressure from empty pipeline
    base = xfer_count;
    rsp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      for (int i = 0; i < N; i++)
        if (k == 0 || taken[i]) begin
          req_a[8*i +: 8] = 8'($urandom);
          req_b[8*i +: 8] = 8'($urandom);
        end
      req_valid = '1;
      at_neg();
      if (k >= 2) check("t4_ready_low", 32'(req_ready), 32'd0);
    end
    check("t4_accepted", 32'(xfer_count - base), 32'd2);
    tick();
    rsp_ready = 1'b1; req_valid = '0;
    repeat (4) tick();
    at_neg();
    check("t4_drained", 32'(sbq.size()), 32'd0);

    // 5: req 2 held, req 1 pulses; pointer frozen when idle
    tick();
    req_valid = 4'b0100;
    repeat (3) begin
      tick();
      if (taken[2]) req_a[23:16] = 8'($urandom);
    end
    req_valid[1] = 1'b1; req_a[15:8] = 8'h33; req_b[15:8] = 8'h44;
    waitc = 0;
    at_neg();
    while (!taken[1] && waitc < 8) begin
      tick();
      at_neg();
      waitc++;
    end
    check("t5_req1_granted_within_turn", 32'(waitc <= 1), 32'd1);
    tick();
    req_valid = 4'b0100;
    at_neg();
    check("t5_req2_only", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    repeat (4) tick();
    req_valid = '1;
    at_neg();
    check("t5_ptr_held", 32'(req_ready), 32'b1000);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // 6: reset with both stages full
    rsp_ready = 1'b0; req_valid = '1;
    repeat (3) tick();
    rst = 1'b1;
    at_neg();
    check("t6_ready_in_rst", 32'(req_ready), 32'd0);
    tick();
    rst = 1'b0; rsp_ready = 1'b1; req_valid = 4'b0110;
    at_neg();
    check("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    check("t6_idle", 32'(idle), 32'd1);
    check("t6_first_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    repeat (3) tick();

    // Random scoreboard traffic
    base = xfer_count; guard = 0; rdy_pct = 70;
    while ((xfer_count - base) < 10000 && guard < 60000) begin
      tick();
      if (guard % 500 == 0) rdy_pct = int'($urandom_range(100, 15));
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || taken[i]) begin
          req_valid[i]    = ($urandom_range(99) < 65);
          req_a[8*i +: 8] = ($urandom_range(9) == 0) ? 8'h00 : 8'($urandom);
          req_b[8*i +: 8] = ($urandom_range(9) == 0) ? 8'h01 : 8'($urandom);
        end
      end
      rsp_ready = ($urandom_range(99) < 32'(rdy_pct));
      guard++;
    end
    check("rand_ops_done", 32'((xfer_count - base) >= 10000), 32'd1);
    req_valid = '0; rsp_ready = 1'b1;
    guard = 0;
    while (sbq.size() != 0 && guard < 20) begin
      tick();
      guard++;
    end
    at_neg();
    check("final_queue_empty", 32'(sbq.size()), 32'd0);
    check("final_idle", 32'(idle), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
